data_bus_ctrl: RTL and testbench
================================

// Module: data_bus_ctrl
// PURPOSE
//  Handshaked data-memory bus controller between the LEGv8 core and data memory.
//  Replaces the combinational tristate DDB/DAB path with a registered valid/ready transaction.
//  Supports byte/half/word/doubleword access with lane steering and zero or sign extension (LDURB/H/SW, STURB/H/W).
//  Stalls the core (holds PC) until each access completes, errors, or times out.
// PARAMETERS
//  DATA_W   64   data bus width; legal values 32 or 64
//  ADDR_W   64   address width
//  TIMEOUT  255  max wait cycles for mem_ready before abort; 0 disables the timeout
// PORTS
//  clk         in   1          clock; all state updates on rising edge
//  rst         in   1          synchronous, active-high reset
//  req_rd      in   1          core load request; held stable while stall=1
//  req_wr      in   1          core store request; held stable while stall=1
//  req_size    in   2          0=B 1=H 2=W 3=D
//  req_signed  in   1          sign-extend load result
//  req_addr    in   ADDR_W     byte address
//  req_wdata   in   DATA_W     store data, right-justified
//  rsp_rdata   out  DATA_W     extended load data; valid in RESP cycle
//  stall       out  1          hold core state
//  err         out  1          one-cycle pulse: misaligned, illegal, or timeout
//  mem_valid   out  1          transaction request (registered)
//  mem_ready   in   1          memory accepts/completes in this cycle
//  mem_we      out  1          1=write
//  mem_addr    out  ADDR_W     req_addr with low log2(DATA_W/8) bits cleared
//  mem_wstrb   out  DATA_W/8   byte-lane enables for writes; all ones for reads
//  mem_wdata   out  DATA_W     lane-shifted store data
//  mem_rdata   in   DATA_W     read data; sampled when mem_valid&mem_ready
// BEHAVIOUR
//  States: IDLE, ACCESS, RESP, ERR. Reset -> IDLE.
//  Reset values: mem_valid=0, mem_we=0, mem_addr=0, mem_wstrb=0, mem_wdata=0, rsp_rdata=0, err=0, timeout count=0.
//  IDLE: stall = req_rd|req_wr (combinational).
//   - Legal request: latch addr, size, signed, rd/wr, and steered data; next state ACCESS.
//   - Illegal request: next state ERR. Illegal means misaligned (addr % 2^size != 0),
//     req_rd&req_wr both high, or size=D with DATA_W=32.
//  ACCESS: mem_valid=1 and stall=1. mem_addr, mem_we, mem_wstrb and mem_wdata stay stable until mem_ready.
//   - mem_ready=1: capture the extended read into rsp_rdata; next state RESP.
//   - Timeout counter increments each cycle without ready. With TIMEOUT!=0, after TIMEOUT
//     unready cycles: mem_valid drops, next state ERR.
//  RESP: stall=0, mem_valid=0; the core advances at this edge. RESP -> IDLE unconditionally;
//   the still-asserted request is NOT relaunched.
//  ERR: err=1, stall=0, mem_valid=0, rsp_rdata unchanged. ERR -> IDLE.
//  Minimum latency with zero-wait memory: stall high 2 cycles, released in cycle 3. Each wait state adds 1.
//  Lane = addr[log2(DATA_W/8)-1:0].
//   - Write: wdata shifted left by lane*8; wstrb = ((1<<2^size)-1) << lane.
//   - Read: mem_rdata >> lane*8, masked to 2^size bytes, then zero- or sign-extended to DATA_W.
//   - Size D: lane must be 0.
//  Timeout counter width is $clog2(TIMEOUT+1); it clears on entry to ACCESS.
//  Reset asserted mid-ACCESS: mem_valid=0 the next cycle, and the memory must discard the
//   abandoned transaction. No err pulse on reset.
//  A request that drops while in ACCESS (protocol violation) is ignored: the latched transaction completes.
// STRUCTURE
//  common.vh: size codes (SZ_B/H/W/D), state encodings, lane-width macro.
//  Submodule mem_lane_align (combinational): write steering/strobe generation and read extract/extend.
//  Top holds the FSM, latches and timeout counter.
// TESTING
//  1 LDUR D @0x10, mem_ready tied 1, mem_rdata=0x1122334455667788 -> stall=1 two cycles,
//    mem_addr=0x10, wstrb=0xFF, rsp_rdata=0x1122334455667788 in RESP.
//  2 LDURB @0x13, lane3=0x80: signed -> rsp_rdata=0xFFFFFFFFFFFFFF80; unsigned -> 0x80.
//    LDURSW @0x4 with rdata[63:32]=0x8000_0001 -> 0xFFFFFFFF80000001.
//  3 STURH @0x6, wdata=0xABCD -> mem_we=1, mem_addr=0x0, mem_wstrb=0xC0, mem_wdata[63:48]=0xABCD.
//  4 LDUR with mem_ready delayed 3 cycles -> mem_valid held 4 cycles, addr stable,
//    stall released 1 cycle after ready.
//  5 LDUR W @0x2 -> no mem_valid, err=1 for 1 cycle, stall=1 for 1 cycle.
//    req_rd&req_wr both high -> same response.
//  6 TIMEOUT=4, mem_ready stuck 0 -> mem_valid high 4 cycles then 0, err pulse.
//    Separately: rst asserted in ACCESS -> mem_valid=0 next cycle, err=0.

Source files
------------

// File: rtl/data_bus_ctrl_pkg.sv
// Shared types for the LEGv8 data-memory bus controller.
// Contents:
//   size_e   - access size codes (byte/half/word/doubleword)
//   state_e  - controller FSM states
//   is_aligned() - natural-alignment test for a byte address and size
package data_bus_ctrl_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2,
        ST_ERR    = 2'd3
    } state_e;

    // An access of 2^size bytes must start on a 2^size byte boundary.
    function automatic logic is_aligned(input logic [2:0] addr_lo, input size_e size);
        logic ok;
        case (size)
            SZ_B:    ok = 1'b1;
            SZ_H:    ok = (addr_lo[0] == 1'b0);
            SZ_W:    ok = (addr_lo[1:0] == 2'b00);
            default: ok = (addr_lo == 3'b000);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/data_bus_ctrl_if.sv
// Core-request and memory-bus signal bundle for data_bus_ctrl.
//   master : controller view (consumes core requests and memory replies,
//            drives the memory request, stall, err and load result)
//   slave  : environment view (core + data memory)
interface data_bus_ctrl_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64
);
    // core side
    logic              req_rd;
    logic              req_wr;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [DATA_W-1:0] rsp_rdata;
    logic              stall;
    logic              err;
    // memory side
    logic              mem_valid;
    logic              mem_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W/8-1:0] mem_wstrb;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  req_rd, req_wr, req_size, req_signed, req_addr, req_wdata,
        input  mem_ready, mem_rdata,
        output rsp_rdata, stall, err,
        output mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata
    );

    modport slave (
        output req_rd, req_wr, req_size, req_signed, req_addr, req_wdata,
        output mem_ready, mem_rdata,
        input  rsp_rdata, stall, err,
        input  mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata
    );

endinterface

// File: rtl/data_bus_ctrl_mem_lane_align.sv
// Combinational byte-lane steering for the data bus.
//   Write path: wdata_i shifted into its lane, byte strobes for the access.
//   Read path : rdata_i shifted down from its lane, trimmed to the access
//               size and zero- or sign-extended to the full bus width.
// Ports:
//   wr_size_i, wr_lane_i, wdata_i -> wstrb_o, wdata_o
//   rd_size_i, rd_lane_i, rd_signed_i, rdata_i -> rdata_o
module data_bus_ctrl_mem_lane_align
    import data_bus_ctrl_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int LANE_W = $clog2(DATA_W / 8)
) (
    input  size_e              wr_size_i,
    input  logic [LANE_W-1:0]  wr_lane_i,
    input  logic [DATA_W-1:0]  wdata_i,
    output logic [DATA_W/8-1:0] wstrb_o,
    output logic [DATA_W-1:0]  wdata_o,
    input  size_e              rd_size_i,
    input  logic [LANE_W-1:0]  rd_lane_i,
    input  logic               rd_signed_i,
    input  logic [DATA_W-1:0]  rdata_i,
    output logic [DATA_W-1:0]  rdata_o
);
    localparam int NBYTES = DATA_W / 8;

    logic [31:0]       wr_lo;
    logic [31:0]       wr_hi;
    logic [31:0]       rd_nbytes;
    logic [DATA_W-1:0] rd_shifted;
    logic              rd_fill;

    assign wr_lo      = 32'(wr_lane_i);
    assign wr_hi      = wr_lo + (32'd1 << wr_size_i);
    assign wdata_o    = wdata_i << {wr_lane_i, 3'b000};
    assign rd_shifted = rdata_i >> {rd_lane_i, 3'b000};
    assign rd_nbytes  = 32'd1 << rd_size_i;

    // Fill value for bytes above the access: the top bit of the loaded
    // field when sign-extending, otherwise zero.
    always_comb begin
        rd_fill = 1'b0;
        case (rd_size_i)
            SZ_B:    rd_fill = rd_shifted[7];
            SZ_H:    rd_fill = rd_shifted[15];
            SZ_W:    rd_fill = rd_shifted[31];
            default: rd_fill = rd_shifted[DATA_W-1];
        endcase
        rd_fill = rd_fill & rd_signed_i;
    end

    generate
        for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
            assign wstrb_o[gi]         = (32'(gi) >= wr_lo) && (32'(gi) < wr_hi);
            assign rdata_o[8*gi +: 8]  = (32'(gi) < rd_nbytes) ? rd_shifted[8*gi +: 8]
                                                               : {8{rd_fill}};
        end
    endgenerate

endmodule

// File: rtl/data_bus_ctrl.sv
// Handshaked data-memory bus controller between the LEGv8 core and data memory.
// A core load/store is checked, latched and presented to memory as a registered
// valid/ready transaction; the core is stalled until the access completes,
// is rejected (misaligned/illegal) or times out.
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - synchronous active-high reset
//   bus  - data_bus_ctrl_if.master (core request/response + memory bus)
module data_bus_ctrl
    import data_bus_ctrl_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    data_bus_ctrl_if.master bus
);
    localparam int STRB_W = DATA_W / 8;
    localparam int LANE_W = $clog2(STRB_W);
    localparam int CNT_W  = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mem_valid_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [STRB_W-1:0] mem_wstrb_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    size_e             size_q;
    logic              signed_q;
    logic [LANE_W-1:0] lane_q;

    size_e             req_size;
    logic [LANE_W-1:0] req_lane;
    logic              req_any;
    logic              req_illegal;
    logic              launch;
    logic              capture;
    logic              stall;
    logic [STRB_W-1:0] wstrb_steer;
    logic [DATA_W-1:0] wdata_steer;
    logic [DATA_W-1:0] rdata_ext;

    assign req_size    = size_e'(bus.req_size);
    assign req_lane    = bus.req_addr[LANE_W-1:0];
    assign req_any     = bus.req_rd | bus.req_wr;
    assign req_illegal = !is_aligned(bus.req_addr[2:0], req_size)
                       || (bus.req_rd && bus.req_wr)
                       || ((req_size == SZ_D) && (DATA_W == 32));

    // Write steering uses the live request (latched at launch); read
    // extraction uses the latched size/lane so it is valid when ready arrives.
    data_bus_ctrl_mem_lane_align #(
        .DATA_W (DATA_W),
        .LANE_W (LANE_W)
    ) u_align (
        .wr_size_i   (req_size),
        .wr_lane_i   (req_lane),
        .wdata_i     (bus.req_wdata),
        .wstrb_o     (wstrb_steer),
        .wdata_o     (wdata_steer),
        .rd_size_i   (size_q),
        .rd_lane_i   (lane_q),
        .rd_signed_i (signed_q),
        .rdata_i     (bus.mem_rdata),
        .rdata_o     (rdata_ext)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        launch  = 1'b0;
        capture = 1'b0;
        stall   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                stall = req_any;
                if (req_any) begin
                    if (req_illegal) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_ACCESS;
                        launch  = 1'b1;
                        cnt_d   = '0;
                    end
                end
            end
            ST_ACCESS: begin
                stall = 1'b1;
                if (bus.mem_ready) begin
                    state_d = ST_RESP;
                    capture = 1'b1;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    state_d = ST_ERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            // RESP and ERR always return to IDLE so a request still held by
            // the core is never relaunched from here.
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wstrb_q <= '0;
            mem_wdata_q <= '0;
            rsp_rdata_q <= '0;
            size_q      <= SZ_B;
            signed_q    <= 1'b0;
            lane_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_valid_q <= (state_d == ST_ACCESS);
            if (launch) begin
                mem_we_q    <= bus.req_wr;
                mem_addr_q  <= {bus.req_addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
                mem_wstrb_q <= bus.req_wr ? wstrb_steer : '1;
                mem_wdata_q <= wdata_steer;
                size_q      <= req_size;
                signed_q    <= bus.req_signed;
                lane_q      <= req_lane;
            end
            if (capture && !mem_we_q) begin
                rsp_rdata_q <= rdata_ext;
            end
        end
    end

    assign bus.stall     = stall;
    assign bus.err       = (state_q == ST_ERR);
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.mem_valid = mem_valid_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wstrb = mem_wstrb_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_data_bus_ctrl.sv
// Bench for data_bus_ctrl (64-bit bus, TIMEOUT=4).
module tb_data_bus_ctrl;
    import data_bus_ctrl_pkg::*;

    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_bus_ctrl_if #(.DATA_W(64), .ADDR_W(64)) bus ();

    data_bus_ctrl #(.DATA_W(64), .ADDR_W(64), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Observations of the most recent transaction.
    int          ob_stall, ob_valid, ob_err;
    logic [63:0] ob_addr, ob_wdata, ob_rsp;
    logic [7:0]  ob_strb;
    logic        ob_we, ob_stable, ob_relaunch;

    // ---------------- reference model ----------------
    function automatic int m_nbytes(input logic [1:0] s);
        return 1 << s;
    endfunction

    function automatic bit m_illegal(input bit rd, input bit wr, input logic [1:0] s,
                                     input logic [63:0] a);
        return (rd && wr) || ((a % 64'(m_nbytes(s))) != 0);
    endfunction

    function automatic logic [7:0] m_strb(input logic [1:0] s, input logic [63:0] a);
        int unsigned v;
        v = ((32'd1 << m_nbytes(s)) - 32'd1) << (a % 8);
        return v[7:0];
    endfunction

    function automatic logic [63:0] m_wdata(input logic [63:0] wd, input logic [63:0] a);
        return wd << (8 * (a % 8));
    endfunction

    function automatic logic [63:0] m_load(input logic [63:0] rdat, input logic [1:0] s,
                                           input bit sgn, input logic [63:0] a);
        longint unsigned v, span;
        int nb;
        nb = m_nbytes(s);
        v  = rdat >> (8 * (a % 8));
        if (nb < 8) begin
            span = 64'd1 << (8 * nb);
            v    = v % span;
            if (sgn && (v >= span / 2)) v = v - span;
        end
        return v;
    endfunction

    // ---------------- transaction driver (no checking) ----------------
    // Called at posedge+1 of an idle cycle; memory answers after `waits`
    // unready cycles. Returns at posedge+1 of a following idle cycle.
    task automatic do_txn(input bit rd, input bit wr, input logic [1:0] s, input bit sgn,
                          input logic [63:0] a, input logic [63:0] wd,
                          input logic [63:0] rdat, input int waits);
        int wcnt;
        bit done;
        bit first;
        wcnt = 0; done = 0; first = 1;
        ob_stall = 0; ob_valid = 0; ob_err = 0; ob_stable = 1;
        ob_addr = '0; ob_wdata = '0; ob_strb = '0; ob_we = 0; ob_rsp = '0;
        bus.req_rd = rd; bus.req_wr = wr; bus.req_size = s; bus.req_signed = sgn;
        bus.req_addr = a; bus.req_wdata = wd; bus.mem_rdata = rdat;
        for (int c = 0; c < 16 && !done; c++) begin
            bus.mem_ready = bus.mem_valid && (wcnt >= waits);
            #4;
            if (bus.stall) ob_stall++;
            if (bus.err) ob_err++;
            if (bus.mem_valid) begin
                ob_valid++;
                if (first) begin
                    ob_addr = bus.mem_addr; ob_we = bus.mem_we;
                    ob_strb = bus.mem_wstrb; ob_wdata = bus.mem_wdata;
                    first = 0;
                end else if ({bus.mem_addr, bus.mem_we, bus.mem_wstrb, bus.mem_wdata}
                             !== {ob_addr, ob_we, ob_strb, ob_wdata}) begin
                    ob_stable = 0;
                end
                if (!bus.mem_ready) wcnt++;
            end
            if (!bus.stall) begin
                done   = 1;
                ob_rsp = bus.rsp_rdata;
            end
            @(posedge clk); #1;
        end
        // Request still held for half of the following cycle.
        bus.mem_ready = 1'b0;
        #4;
        ob_relaunch = bus.mem_valid;
        bus.req_rd = 1'b0; bus.req_wr = 1'b0;
        @(posedge clk); #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bus.req_rd = 0; bus.req_wr = 0; bus.req_size = 0; bus.req_signed = 0;
        bus.req_addr = '0; bus.req_wdata = '0; bus.mem_ready = 0; bus.mem_rdata = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #5;
        n_vec++;
        if ({bus.mem_valid, bus.err, bus.stall} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset ctl: got valid/err/stall=%b want 000",
                     {bus.mem_valid, bus.err, bus.stall});
        end
        n_vec++;
        if ({bus.mem_we, bus.mem_addr, bus.mem_wstrb, bus.mem_wdata, bus.rsp_rdata} !== '0) begin
            n_bad++;
            $display("FAIL reset data: addr=%h strb=%h wdata=%h rsp=%h want all 0",
                     bus.mem_addr, bus.mem_wstrb, bus.mem_wdata, bus.rsp_rdata);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        $display("reset checked");
    endtask

    task automatic test_ldur_d();
        do_txn(1, 0, SZ_D, 0, 64'h10, 64'h0, 64'h1122334455667788, 0);
        $display("LDUR D @10: stall=%0d valid=%0d addr=%h strb=%h rsp=%h",
                 ob_stall, ob_valid, ob_addr, ob_strb, ob_rsp);
        n_vec++;
        if (ob_stall !== 2 || ob_valid !== 1 || ob_err !== 0) begin
            n_bad++;
            $display("FAIL ldur_d timing: got stall=%0d valid=%0d err=%0d want 2 1 0",
                     ob_stall, ob_valid, ob_err);
        end
        n_vec++;
        if (ob_addr !== 64'h10 || ob_strb !== 8'hFF || ob_we !== 1'b0) begin
            n_bad++;
            $display("FAIL ldur_d bus: got addr=%h strb=%h we=%b want 10 ff 0",
                     ob_addr, ob_strb, ob_we);
        end
        n_vec++;
        if (ob_rsp !== 64'h1122334455667788) begin
            n_bad++;
            $display("FAIL ldur_d rsp: got %h want 1122334455667788", ob_rsp);
        end
        n_vec++;
        if (ob_relaunch !== 1'b0) begin
            n_bad++;
            $display("FAIL ldur_d relaunch: got mem_valid=%b want 0", ob_relaunch);
        end
    endtask

    task automatic test_sign_ext();
        do_txn(1, 0, SZ_B, 1, 64'h13, 64'h0, 64'h5A5A5A5A805A5A5A, 0);
        $display("LDURSB @13: rsp=%h", ob_rsp);
        n_vec++;
        if (ob_rsp !== 64'hFFFFFFFFFFFFFF80) begin
            n_bad++;
            $display("FAIL ldursb rsp: got %h want ffffffffffffff80", ob_rsp);
        end
        do_txn(1, 0, SZ_B, 0, 64'h13, 64'h0, 64'h5A5A5A5A805A5A5A, 0);
        $display("LDURB @13: rsp=%h", ob_rsp);
        n_vec++;
        if (ob_rsp !== 64'h80) begin
            n_bad++;
            $display("FAIL ldurb rsp: got %h want 80", ob_rsp);
        end
        do_txn(1, 0, SZ_W, 1, 64'h4, 64'h0, 64'h8000000100000000, 0);
        $display("LDURSW @4: rsp=%h", ob_rsp);
        n_vec++;
        if (ob_rsp !== 64'hFFFFFFFF80000001) begin
            n_bad++;
            $display("FAIL ldursw rsp: got %h want ffffffff80000001", ob_rsp);
        end
    endtask

    task automatic test_sturh();
        do_txn(0, 1, SZ_H, 0, 64'h6, 64'hABCD, 64'h0, 0);
        $display("STURH @6: we=%b addr=%h strb=%h wdata=%h", ob_we, ob_addr, ob_strb, ob_wdata);
        n_vec++;
        if (ob_we !== 1'b1 || ob_addr !== 64'h0 || ob_strb !== 8'hC0) begin
            n_bad++;
            $display("FAIL sturh bus: got we=%b addr=%h strb=%h want 1 0 c0",
                     ob_we, ob_addr, ob_strb);
        end
        n_vec++;
        if (ob_wdata[63:48] !== 16'hABCD) begin
            n_bad++;
            $display("FAIL sturh wdata: got %h want abcd", ob_wdata[63:48]);
        end
    endtask

    task automatic test_wait_states();
        do_txn(1, 0, SZ_D, 0, 64'h28, 64'h0, 64'hCAFEF00D12345678, 3);
        $display("LDUR 3 waits: stall=%0d valid=%0d stable=%b rsp=%h",
                 ob_stall, ob_valid, ob_stable, ob_rsp);
        n_vec++;
        if (ob_valid !== 4 || ob_stall !== 5 || ob_stable !== 1'b1 || ob_addr !== 64'h28) begin
            n_bad++;
            $display("FAIL wait3: got valid=%0d stall=%0d stable=%b addr=%h want 4 5 1 28",
                     ob_valid, ob_stall, ob_stable, ob_addr);
        end
        n_vec++;
        if (ob_rsp !== 64'hCAFEF00D12345678) begin
            n_bad++;
            $display("FAIL wait3 rsp: got %h want cafef00d12345678", ob_rsp);
        end
    endtask

    task automatic test_illegal();
        do_txn(1, 0, SZ_W, 0, 64'h2, 64'h0, 64'h0, 0);
        $display("LDUR W @2: stall=%0d valid=%0d err=%0d", ob_stall, ob_valid, ob_err);
        n_vec++;
        if (ob_valid !== 0 || ob_err !== 1 || ob_stall !== 1) begin
            n_bad++;
            $display("FAIL misaligned: got valid=%0d err=%0d stall=%0d want 0 1 1",
                     ob_valid, ob_err, ob_stall);
        end
        do_txn(1, 1, SZ_D, 0, 64'h8, 64'h0, 64'h0, 0);
        $display("rd&wr: stall=%0d valid=%0d err=%0d", ob_stall, ob_valid, ob_err);
        n_vec++;
        if (ob_valid !== 0 || ob_err !== 1 || ob_stall !== 1) begin
            n_bad++;
            $display("FAIL rd_and_wr: got valid=%0d err=%0d stall=%0d want 0 1 1",
                     ob_valid, ob_err, ob_stall);
        end
    endtask

    task automatic test_timeout_and_reset();
        // Previous successful load left cafef00d12345678 in rsp_rdata.
        do_txn(1, 0, SZ_D, 0, 64'h40, 64'h0, 64'h0123456789ABCDEF, 100);
        $display("timeout: stall=%0d valid=%0d err=%0d rsp=%h", ob_stall, ob_valid, ob_err, ob_rsp);
        n_vec++;
        if (ob_valid !== TO || ob_err !== 1 || ob_stall !== TO + 1) begin
            n_bad++;
            $display("FAIL timeout: got valid=%0d err=%0d stall=%0d want %0d 1 %0d",
                     ob_valid, ob_err, ob_stall, TO, TO + 1);
        end
        n_vec++;
        if (ob_rsp !== 64'hCAFEF00D12345678) begin
            n_bad++;
            $display("FAIL timeout rsp kept: got %h want cafef00d12345678", ob_rsp);
        end
        // Reset while the access is outstanding.
        bus.req_rd = 1; bus.req_wr = 0; bus.req_size = SZ_D; bus.req_addr = 64'h80;
        bus.mem_ready = 0;
        @(posedge clk); #5;
        n_vec++;
        if (bus.mem_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid access entry: got mem_valid=%b want 1", bus.mem_valid);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; bus.req_rd = 0;
        #4;
        $display("reset in ACCESS: mem_valid=%b err=%b", bus.mem_valid, bus.err);
        n_vec++;
        if (bus.mem_valid !== 1'b0 || bus.err !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid: got mem_valid=%b err=%b want 0 0", bus.mem_valid, bus.err);
        end
        @(posedge clk); #5;
        n_vec++;
        if (bus.err !== 1'b0 || bus.mem_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid after: got err=%b mem_valid=%b want 0 0", bus.err, bus.mem_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random(input int n);
        for (int i = 0; i < n; i++) begin
            bit rd, wr, sgn, bad;
            logic [1:0] sz;
            logic [63:0] a, wd, rdat, e_rsp;
            int w, k, e_stall, e_valid, e_err;
            k    = $urandom_range(0, 9);
            rd   = (k < 5) || (k == 9);
            wr   = (k >= 5);
            sz   = 2'($urandom_range(0, 3));
            sgn  = 1'($urandom_range(0, 1));
            a    = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) a = a & ~(64'(m_nbytes(sz)) - 64'd1);
            wd   = {$urandom, $urandom};
            rdat = {$urandom, $urandom};
            w    = $urandom_range(0, 5);
            if (w == 5) w = 7;
            bad  = m_illegal(rd, wr, sz, a);
            if (bad) begin
                e_stall = 1; e_valid = 0; e_err = 1;
            end else if (w >= TO) begin
                e_stall = TO + 1; e_valid = TO; e_err = 1;
            end else begin
                e_stall = 2 + w; e_valid = 1 + w; e_err = 0;
            end
            do_txn(rd, wr, sz, sgn, a, wd, rdat, w);
            $display("rand %0d rd=%b wr=%b sz=%0d s=%b a=%h w=%0d: stall=%0d valid=%0d err=%0d rsp=%h",
                     i, rd, wr, sz, sgn, a, w, ob_stall, ob_valid, ob_err, ob_rsp);
            n_vec++;
            if (ob_stall !== e_stall || ob_valid !== e_valid || ob_err !== e_err) begin
                n_bad++;
                $display("FAIL rand%0d timing: got stall=%0d valid=%0d err=%0d want %0d %0d %0d",
                         i, ob_stall, ob_valid, ob_err, e_stall, e_valid, e_err);
            end
            n_vec++;
            if (ob_relaunch !== 1'b0) begin
                n_bad++;
                $display("FAIL rand%0d relaunch: got mem_valid=%b want 0", i, ob_relaunch);
            end
            if (!bad) begin
                n_vec++;
                if (ob_addr !== (a & ~64'd7) || ob_we !== wr || ob_stable !== 1'b1) begin
                    n_bad++;
                    $display("FAIL rand%0d bus: got addr=%h we=%b stable=%b want %h %b 1",
                             i, ob_addr, ob_we, ob_stable, a & ~64'd7, wr);
                end
                n_vec++;
                if (ob_strb !== (wr ? m_strb(sz, a) : 8'hFF)) begin
                    n_bad++;
                    $display("FAIL rand%0d strb: got %h want %h", i, ob_strb,
                             wr ? m_strb(sz, a) : 8'hFF);
                end
                if (wr) begin
                    n_vec++;
                    if (ob_wdata !== m_wdata(wd, a)) begin
                        n_bad++;
                        $display("FAIL rand%0d wdata: got %h want %h", i, ob_wdata, m_wdata(wd, a));
                    end
                end else if (w < TO) begin
                    e_rsp = m_load(rdat, sz, sgn, a);
                    n_vec++;
                    if (ob_rsp !== e_rsp) begin
                        n_bad++;
                        $display("FAIL rand%0d rsp: got %h want %h", i, ob_rsp, e_rsp);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_ldur_d();
        test_sign_ext();
        test_sturh();
        test_wait_states();
        test_illegal();
        test_timeout_and_reset();
        test_random(60);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
